// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT bin collector.
// Build option: FFT_PEAK_EN compiles in peak-bin tracking in fft_bin_collect.
package fft_pkg;

   // Depth of the squarer/adder pipeline; DRAIN waits this many cycles.
   localparam int PIPE_DEPTH = 2;

   // Default component width and the matching power-word width (2*RN).
   localparam int DEF_RN = 16;
   localparam int DEF_PW = 2 * DEF_RN;

   // Power word for the default configuration.
   typedef logic [DEF_PW-1:0] pwr_t;

   // Collector FSM states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2,
      COMMIT  = 2'd3
   } state_t;

endpackage

// File: rtl/fft_pwr.sv
// Two-stage bin power pipeline: squares registered, then their sum registered.
// A valid bit and the bin index travel alongside the data. flush drops any
// bins already in flight while still accepting the bin presented this cycle.
module fft_pwr
   import fft_pkg::*;
#(
   parameter int RN = 16,
   parameter int PW = 2 * RN,
   parameter int AW = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   input  logic [AW-1:0]        in_idx,
   input  logic signed [RN-1:0] in_re,
   input  logic signed [RN-1:0] in_im,
   output logic                 out_valid,
   output logic [AW-1:0]        out_idx,
   output logic [PW-1:0]        out_pwr
);

   // Sign-extend to full product width so the squares are exact.
   logic signed [PW-1:0] re_x;
   logic signed [PW-1:0] im_x;
   logic signed [PW-1:0] re_sq;
   logic signed [PW-1:0] im_sq;

   // Stage 1 registers.
   logic          s1_valid;
   logic [AW-1:0] s1_idx;
   logic [PW-1:0] s1_re_sq;
   logic [PW-1:0] s1_im_sq;

   assign re_x  = {{(PW-RN){in_re[RN-1]}}, in_re};
   assign im_x  = {{(PW-RN){in_im[RN-1]}}, im_x_src(in_im)};
   assign re_sq = re_x * re_x;
   assign im_sq = im_x * im_x;

   // Identity helper keeps both extension expressions symmetrical.
   function automatic logic [RN-1:0] im_x_src(input logic [RN-1:0] v);
      return v;
   endfunction

   // Valid sideband: cleared on reset; flush removes the bin in stage 1.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         s1_valid  <= in_valid;
         out_valid <= s1_valid & ~flush;
      end
   end

   // Datapath: squares are non-negative, their sum peaks at 2^(PW-1).
   always_ff @(posedge clk) begin
      s1_idx   <= in_idx;
      s1_re_sq <= re_sq;
      s1_im_sq <= im_sq;
      out_idx  <= s1_idx;
      out_pwr  <= s1_re_sq + s1_im_sq;
   end

endmodule

// File: rtl/fft_bin_collect.sv
// Collects one FFT frame of complex bins, converts each to power, and stores
// it in a ping-pong bank pair. A completed frame is published to the read bank
// unless hold is high, in which case it is dropped and counted.
// Build option: FFT_PEAK_EN adds peak-bin tracking (peak_bin/peak_pwr).
//
// Streaming input: there is no backpressure. in_first qualifies bin 0 and the
// remaining SIZE-1 bins must follow on consecutive cycles; anything presented
// outside an open frame is ignored. frame_ready is a single-cycle strobe with
// no acknowledge; hold is a level that freezes the read bank.
module fft_bin_collect
   import fft_pkg::*;
#(
   parameter int  SIZE = 16,
   parameter int  RN   = 16,
   localparam int PW   = 2 * RN,
   localparam int AW   = $clog2(SIZE)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_first,
   input  logic [1:0][RN-1:0]   in_bin,
   input  logic                 hold,
   input  logic [AW-1:0]        rd_addr,
   output logic [PW-1:0]        rd_data,
   output logic                 frame_ready,
   output logic [AW-1:0]        peak_bin,
   output logic [PW-1:0]        peak_pwr,
   output logic [7:0]           drop_cnt,
   output state_t               fsm_state
);

   localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

   state_t        state;
   state_t        next_state;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] bin_idx;
   logic [DW-1:0] drain_cnt;
   logic          accept;
   logic          restart;
   logic          bank_sel;

   logic          p_valid;
   logic [AW-1:0] p_idx;
   logic [PW-1:0] p_pwr;

   // Bank bank_sel is the read bank; the other is being filled.
   logic [PW-1:0] bank_mem [2*SIZE];

   assign fsm_state = state;

   // Next-state and bin acceptance; in_first (re)opens a frame at index 0.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      restart    = 1'b0;
      bin_idx    = wr_idx;
      case (state)
         IDLE: begin
            if (in_first) begin
               accept     = 1'b1;
               restart    = 1'b1;
               bin_idx    = '0;
               next_state = COLLECT;
            end
         end
         COLLECT: begin
            accept = 1'b1;
            if (in_first) begin
               restart = 1'b1;
               bin_idx = '0;
            end else if (wr_idx == AW'(SIZE - 1)) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_cnt == DW'(PIPE_DEPTH - 1)) next_state = COMMIT;
         end
         COMMIT: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State register, write index and drain counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         wr_idx    <= '0;
         drain_cnt <= '0;
      end else begin
         state <= next_state;
         if (accept) wr_idx <= bin_idx + 1'b1;
         drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
      end
   end

   fft_pwr #(
      .RN (RN),
      .PW (PW),
      .AW (AW)
   ) u_pwr (
      .clk       (clk),
      .reset     (reset),
      .flush     (restart),
      .in_valid  (accept),
      .in_idx    (bin_idx),
      .in_re     (in_bin[0]),
      .in_im     (in_bin[1]),
      .out_valid (p_valid),
      .out_idx   (p_idx),
      .out_pwr   (p_pwr)
   );

   // Commit: swap banks and strobe frame_ready, or drop and count under hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         bank_sel    <= 1'b0;
         frame_ready <= 1'b0;
         drop_cnt    <= '0;
      end else begin
         frame_ready <= 1'b0;
         if (state == COMMIT) begin
            if (!hold) begin
               bank_sel    <= ~bank_sel;
               frame_ready <= 1'b1;
            end else if (drop_cnt != 8'hFF) begin
               drop_cnt <= drop_cnt + 8'd1;
            end
         end
      end
   end

   // Bank storage: pipeline writes the fill bank, reads come from the other.
   always_ff @(posedge clk) begin
      if (p_valid) bank_mem[{~bank_sel, p_idx}] <= p_pwr;
      rd_data <= bank_mem[{bank_sel, rd_addr}];
   end

`ifdef FFT_PEAK_EN
   logic [AW-1:0] trk_bin;
   logic [PW-1:0] trk_pwr;

   // Running maximum over the frame; strict compare keeps the lowest index.
   always_ff @(posedge clk) begin
      if (reset) begin
         trk_bin  <= '0;
         trk_pwr  <= '0;
         peak_bin <= '0;
         peak_pwr <= '0;
      end else begin
         if (restart) begin
            trk_bin <= '0;
            trk_pwr <= '0;
         end else if (p_valid && (p_pwr > trk_pwr)) begin
            trk_bin <= p_idx;
            trk_pwr <= p_pwr;
         end
         if (state == COMMIT && !hold) begin
            peak_bin <= trk_bin;
            peak_pwr <= trk_pwr;
         end
      end
   end
`else
   assign peak_bin = '0;
   assign peak_pwr = '0;
`endif

endmodule

// File: tb/tb_fft_bin_collect.sv
// Directed bench for fft_bin_collect (SIZE=8, RN=16).
module tb_fft_bin_collect;
   import fft_pkg::*;

   localparam int SIZE = 8;
   localparam int RN   = 16;
   localparam int PW   = 32;
   localparam int AW   = 3;
`ifdef FFT_PEAK_EN
   localparam bit PEAK_ON = 1'b1;
`else
   localparam bit PEAK_ON = 1'b0;
`endif

   logic                clk;
   logic                reset;
   logic                in_first;
   logic [1:0][RN-1:0]  in_bin;
   logic                hold;
   logic [AW-1:0]       rd_addr;
   logic [PW-1:0]       rd_data;
   logic                frame_ready;
   logic [AW-1:0]       peak_bin;
   logic [PW-1:0]       peak_pwr;
   logic [7:0]          drop_cnt;
   state_t              fsm_state;

   int checks = 0;
   int passes = 0;
   int ready_total = 0;

   logic signed [RN-1:0] f_re [SIZE];
   logic signed [RN-1:0] f_im [SIZE];

   fft_bin_collect #(.SIZE(SIZE), .RN(RN)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_first    (in_first),
      .in_bin      (in_bin),
      .hold        (hold),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .frame_ready (frame_ready),
      .peak_bin    (peak_bin),
      .peak_pwr    (peak_pwr),
      .drop_cnt    (drop_cnt),
      .fsm_state   (fsm_state)
   );

   // Clock and reset-time input defaults.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count every frame_ready cycle seen.
   always @(negedge clk) if (frame_ready === 1'b1) ready_total++;

   task automatic clear_frame();
      for (int k = 0; k < SIZE; k++) begin
         f_re[k] = '0;
         f_im[k] = '0;
      end
   endtask

   // Drive the first nbins of f_re/f_im, in_first on bin 0, no idle after.
   task automatic drive_frame(input int nbins);
      for (int k = 0; k < nbins; k++) begin
         @(negedge clk);
         in_first  = (k == 0);
         in_bin[0] = f_re[k];
         in_bin[1] = f_im[k];
      end
   endtask

   task automatic idle_inputs();
      @(negedge clk);
      in_first = 1'b0;
      in_bin   = '0;
   endtask

   task automatic settle();
      repeat (6) @(negedge clk);
   endtask

   task automatic read_bin(input int a, output logic [PW-1:0] d);
      @(negedge clk);
      rd_addr = AW'(a);
      @(negedge clk);
      d = rd_data;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_first = 1'b0; in_bin = '0; hold = 1'b0; rd_addr = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if (frame_ready !== 1'b0) $display("FAIL reset_frame_ready: got %0b expected 0", frame_ready); else passes++;
      checks++; if (peak_bin !== 3'd0) $display("FAIL reset_peak_bin: got %0d expected 0", peak_bin); else passes++;
      checks++; if (peak_pwr !== 32'd0) $display("FAIL reset_peak_pwr: got %0d expected 0", peak_pwr); else passes++;
      checks++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); else passes++;
   endtask

   task automatic test_single_bin();
      int r0;
      logic [PW-1:0] d;
      logic [AW-1:0] exp_pb;
      logic [PW-1:0] exp_pp;
      exp_pb = PEAK_ON ? 3'd2 : 3'd0;
      exp_pp = PEAK_ON ? 32'd25 : 32'd0;
      clear_frame();
      f_re[2] = 16'sd3; f_im[2] = 16'sd4;
      r0 = ready_total;
      drive_frame(SIZE); idle_inputs(); settle();
      checks++; if (ready_total - r0 !== 1) $display("FAIL single_pulses: got %0d expected 1", ready_total - r0); else passes++;
      read_bin(2, d);
      checks++; if (d !== 32'd25) $display("FAIL single_rd2: got %0d expected 25", d); else passes++;
      read_bin(3, d);
      checks++; if (d !== 32'd0) $display("FAIL single_rd3: got %0d expected 0", d); else passes++;
      checks++; if (peak_bin !== exp_pb) $display("FAIL single_peak_bin: got %0d expected %0d", peak_bin, exp_pb); else passes++;
      checks++; if (peak_pwr !== exp_pp) $display("FAIL single_peak_pwr: got %0d expected %0d", peak_pwr, exp_pp); else passes++;
   endtask

   task automatic test_min_corner();
      int r0;
      logic [PW-1:0] d;
      logic [PW-1:0] exp_pp;
      exp_pp = PEAK_ON ? 32'h8000_0000 : 32'd0;
      clear_frame();
      f_re[0] = 16'sh8000; f_im[0] = 16'sh8000;
      r0 = ready_total;
      drive_frame(SIZE); idle_inputs(); settle();
      checks++; if (ready_total - r0 !== 1) $display("FAIL corner_pulses: got %0d expected 1", ready_total - r0); else passes++;
      read_bin(0, d);
      checks++; if (d !== 32'h8000_0000) $display("FAIL corner_rd0: got %0h expected 80000000", d); else passes++;
      checks++; if (peak_pwr !== exp_pp) $display("FAIL corner_peak_pwr: got %0h expected %0h", peak_pwr, exp_pp); else passes++;
   endtask

   task automatic test_restart();
      int r0;
      logic [PW-1:0] d;
      logic [AW-1:0] exp_pb;
      logic [PW-1:0] exp_pp;
      exp_pb = PEAK_ON ? 3'd7 : 3'd0;
      exp_pp = PEAK_ON ? 32'd49 : 32'd0;
      clear_frame();
      for (int k = 0; k < 5; k++) f_re[k] = 16'sd100;
      r0 = ready_total;
      drive_frame(5);
      for (int k = 0; k < SIZE; k++) begin
         f_re[k] = RN'(k);
         f_im[k] = '0;
      end
      drive_frame(SIZE);
      checks++; if (ready_total - r0 !== 0) $display("FAIL restart_early_pulse: got %0d expected 0", ready_total - r0); else passes++;
      idle_inputs(); settle();
      checks++; if (ready_total - r0 !== 1) $display("FAIL restart_pulses: got %0d expected 1", ready_total - r0); else passes++;
      read_bin(0, d);
      checks++; if (d !== 32'd0) $display("FAIL restart_rd0: got %0d expected 0", d); else passes++;
      read_bin(4, d);
      checks++; if (d !== 32'd16) $display("FAIL restart_rd4: got %0d expected 16", d); else passes++;
      read_bin(7, d);
      checks++; if (d !== 32'd49) $display("FAIL restart_rd7: got %0d expected 49", d); else passes++;
      checks++; if (peak_bin !== exp_pb || peak_pwr !== exp_pp)
         $display("FAIL restart_peak: got %0d/%0d expected %0d/%0d", peak_bin, peak_pwr, exp_pb, exp_pp);
      else passes++;
   endtask

   task automatic test_hold_drop();
      int r0;
      logic [PW-1:0] d;
      logic [AW-1:0] exp_pb;
      logic [PW-1:0] exp_pp;
      exp_pb = PEAK_ON ? 3'd6 : 3'd0;
      exp_pp = PEAK_ON ? 32'd169 : 32'd0;
      // Frame A published normally.
      clear_frame();
      f_re[6] = 16'sd5; f_im[6] = 16'sd12;
      drive_frame(SIZE); idle_inputs(); settle();
      // Frame B completes under hold.
      hold = 1'b1;
      clear_frame();
      f_re[1] = 16'sd7;
      r0 = ready_total;
      drive_frame(SIZE); idle_inputs(); settle();
      checks++; if (ready_total - r0 !== 0) $display("FAIL hold_pulses: got %0d expected 0", ready_total - r0); else passes++;
      checks++; if (drop_cnt !== 8'd1) $display("FAIL hold_drop1: got %0d expected 1", drop_cnt); else passes++;
      read_bin(6, d);
      checks++; if (d !== 32'd169) $display("FAIL hold_rd6: got %0d expected 169", d); else passes++;
      read_bin(1, d);
      checks++; if (d !== 32'd0) $display("FAIL hold_rd1: got %0d expected 0", d); else passes++;
      checks++; if (peak_bin !== exp_pb) $display("FAIL hold_peak_bin: got %0d expected %0d", peak_bin, exp_pb); else passes++;
      checks++; if (peak_pwr !== exp_pp) $display("FAIL hold_peak_pwr: got %0d expected %0d", peak_pwr, exp_pp); else passes++;
      // 255 more drops saturate the counter.
      for (int n = 0; n < 255; n++) begin
         drive_frame(SIZE); idle_inputs(); settle();
      end
      checks++; if (drop_cnt !== 8'd255) $display("FAIL hold_drop_sat: got %0d expected 255", drop_cnt); else passes++;
      checks++; if (ready_total - r0 !== 0) $display("FAIL hold_sat_pulses: got %0d expected 0", ready_total - r0); else passes++;
      hold = 1'b0;
   endtask

   task automatic test_tie();
      int r0;
      logic [PW-1:0] d;
      logic [AW-1:0] exp_pb;
      logic [PW-1:0] exp_pp;
      exp_pb = PEAK_ON ? 3'd1 : 3'd0;
      exp_pp = PEAK_ON ? 32'd100 : 32'd0;
      clear_frame();
      f_re[1] = 16'sd10; f_re[5] = 16'sd10;
      r0 = ready_total;
      drive_frame(SIZE); idle_inputs(); settle();
      checks++; if (ready_total - r0 !== 1) $display("FAIL tie_pulses: got %0d expected 1", ready_total - r0); else passes++;
      read_bin(5, d);
      checks++; if (d !== 32'd100) $display("FAIL tie_rd5: got %0d expected 100", d); else passes++;
      checks++; if (peak_bin !== exp_pb) $display("FAIL tie_peak_bin: got %0d expected %0d", peak_bin, exp_pb); else passes++;
      checks++; if (peak_pwr !== exp_pp) $display("FAIL tie_peak_pwr: got %0d expected %0d", peak_pwr, exp_pp); else passes++;
   endtask

   initial begin
      test_reset();
      test_single_bin();
      test_min_corner();
      test_restart();
      test_hold_drop();
      test_tie();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/fft_bin_collect.md
FFT_BIN_COLLECT -- requirements
Module: fft_bin_collect

Interface
REQ-001 Parameter SIZE, default 16, FFT length in bins; power of two, 2..128.
REQ-002 Parameter RN, default 16, width of each signed real/imag bin component.
REQ-003 Parameter PW, fixed at 2*RN, width of the unsigned power word.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_first  input  1  marks bin 0 on in_bin; bins 1..SIZE-1 follow on the next SIZE-1 consecutive cycles.
REQ-007 in_bin  input  [RN-1:0] x2  complex bin, element 0 real, element 1 imaginary, two's complement.
REQ-008 hold  input  1  consumer lock; while high the read bank shall not change.
REQ-009 rd_addr  input  [$clog2(SIZE)-1:0]  read bin index.
REQ-010 rd_data  output  [PW-1:0]  power of bin rd_addr in the read bank.
REQ-011 frame_ready  output  1  one-cycle pulse: a new frame is now in the read bank.
REQ-012 peak_bin  output  [$clog2(SIZE)-1:0]  index of the maximum-power bin of the read-bank frame.
REQ-013 peak_pwr  output  [PW-1:0]  power of peak_bin.
REQ-014 drop_cnt  output  [7:0]  count of frames discarded because hold was high.

Function
REQ-015 Power shall be re*re + im*im, computed at full precision and held unsigned in PW bits; (-2^(RN-1), -2^(RN-1)) gives 2^(PW-1) with no overflow.
REQ-016 The power pipeline shall be 2 stages: squares registered, then sum registered and written to the write bank.
REQ-017 The write bank and read bank shall be two SIZE-entry ping-pong banks.
REQ-018 FSM states: IDLE, COLLECT, DRAIN, COMMIT.
REQ-019 IDLE -> COLLECT on in_first; the write index is 0 for that bin and increments each cycle.
REQ-020 COLLECT -> DRAIN after the bin at index SIZE-1 is accepted; DRAIN lasts 2 cycles, until the final write completes.
REQ-021 DRAIN -> COMMIT; in COMMIT with hold low the banks swap, frame_ready pulses for one cycle and the peak registers update. The FSM then returns to IDLE.
REQ-022 In COMMIT with hold high the frame shall be discarded, drop_cnt shall increment (saturating at 255), and the banks and peak outputs shall stay unchanged.
REQ-023 in_first during COLLECT shall discard the partial frame and restart at index 0 with that bin.
REQ-024 in_first during DRAIN or COMMIT shall be ignored; that frame is not collected.
REQ-025 Input bins outside COLLECT and without in_first shall be ignored.
REQ-026 rd_data latency shall be 1 cycle from rd_addr; reads of the read bank are unaffected by writes to the write bank.
REQ-027 Peak tracking shall run on the pipelined power during collection, using strictly-greater compare, so the lowest index wins ties.

Reset
REQ-028 reset shall force: FSM to IDLE, frame_ready 0, peak_bin 0, peak_pwr 0, drop_cnt 0, pipeline valids 0, bank select 0.
REQ-029 Bank contents shall not be cleared; rd_data is undefined until the first frame_ready.
REQ-030 reset mid-frame shall discard the partial frame with no frame_ready.

Configuration
REQ-031 Macro FFT_PEAK_EN: when defined, peak tracking per REQ-027 is compiled in.
REQ-032 When FFT_PEAK_EN is undefined, the tracking logic is omitted and peak_bin and peak_pwr are tied to 0; all other behaviour is identical.

Structure
REQ-033 Package fft_pkg shall hold the FSM state enum, the power-word typedef parameterised via PW, and the pipeline depth constant (2).
REQ-034 Sub-module fft_pwr shall contain the 2-stage squarer/adder pipeline with a valid and an index sideband.

Verification
(Scenarios use SIZE=8, RN=16.)
REQ-035 Reset -> frame_ready 0, peak_bin 0, peak_pwr 0, drop_cnt 0.
REQ-036 Frame with bin 2 = (3,4) and all other bins (0,0) -> frame_ready exactly 1 pulse, rd_addr 2 gives 25 next cycle, peak_bin 2, peak_pwr 25.
REQ-037 Bin 0 = (-32768,-32768) -> rd_addr 0 gives 0x80000000.
REQ-038 in_first, 5 bins, then in_first again -> no frame_ready until 8 bins after the restart; the stored data comes from the restarted frame only.
REQ-039 hold high across completion of frame B after frame A -> no frame_ready, drop_cnt 1, rd_data and peak still frame A. A further 255 drops -> drop_cnt 255.
REQ-040 Bins 1 and 5 both (10,0), others 0 -> peak_bin 1, peak_pwr 100. With FFT_PEAK_EN undefined -> peak_bin 0, peak_pwr 0.
